// File: rtl/exe_stage_mc_if.sv
`default_nettype none
// ============================================================================
// Module   : exe_stage_mc_if
// Purpose  : ID/EX register contents in, EX/MEM payload and freeze out.
//            Macro EXE_OVF_TRAP_EN adds the ovf output.
// Revision : 1.0 - initial release
// ============================================================================
interface exe_stage_mc_if #(
    parameter int DATA_W = 32
);
    logic              flush;
    logic              in_valid;
    logic [DATA_W-1:0] val1;
    logic [DATA_W-1:0] val2;
    logic [DATA_W-1:0] reg2;
    logic [DATA_W-1:0] pc_in;
    logic [4:0]        dest_in;
    logic [1:0]        br_type;
    logic [3:0]        exe_cmd;
    logic              mem_r_en_in;
    logic              mem_w_en_in;
    logic              wb_en_in;

    logic              freeze;
    logic              out_valid;
    logic [DATA_W-1:0] alu_result;
    logic [DATA_W-1:0] st_val;
    logic [4:0]        dest;
    logic              mem_r_en;
    logic              mem_w_en;
    logic              wb_en;
    logic              br_taken;
    logic [DATA_W-1:0] br_addr;
`ifdef EXE_OVF_TRAP_EN
    logic              ovf;
`endif

    modport master (
`ifdef EXE_OVF_TRAP_EN
        input  ovf,
`endif
        output flush, in_valid, val1, val2, reg2, pc_in, dest_in, br_type,
               exe_cmd, mem_r_en_in, mem_w_en_in, wb_en_in,
        input  freeze, out_valid, alu_result, st_val, dest, mem_r_en,
               mem_w_en, wb_en, br_taken, br_addr
    );

    modport slave (
`ifdef EXE_OVF_TRAP_EN
        output ovf,
`endif
        input  flush, in_valid, val1, val2, reg2, pc_in, dest_in, br_type,
               exe_cmd, mem_r_en_in, mem_w_en_in, wb_en_in,
        output freeze, out_valid, alu_result, st_val, dest, mem_r_en,
               mem_w_en, wb_en, br_taken, br_addr
    );
endinterface
`default_nettype wire

// File: rtl/exe_stage_mc.sv
`default_nettype none
// ============================================================================
// Module   : exe_stage_mc
// Purpose  : Multicycle MIPS execute stage: 1-cycle ALU/branch ops plus an
//            iterative shift-add MUL that freezes upstream until done.
//            Macro EXE_OVF_TRAP_EN enables signed-overflow trap (ovf output).
// Revision : 1.0 - initial release
// ============================================================================
module exe_stage_mc #(
    parameter int DATA_W = 32
) (
    input  logic           clk,
    input  logic           rst,
    exe_stage_mc_if.slave  bus
);
    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int MSB   = DATA_W - 1;
    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(DATA_W - 1);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_BUSY = 1'b1;

    localparam logic [3:0] C_CMD_ADD = 4'd0;
    localparam logic [3:0] C_CMD_SUB = 4'd1;
    localparam logic [3:0] C_CMD_AND = 4'd2;
    localparam logic [3:0] C_CMD_OR  = 4'd3;
    localparam logic [3:0] C_CMD_NOR = 4'd4;
    localparam logic [3:0] C_CMD_XOR = 4'd5;
    localparam logic [3:0] C_CMD_SLL = 4'd6;
    localparam logic [3:0] C_CMD_SRA = 4'd7;
    localparam logic [3:0] C_CMD_SRL = 4'd8;
    localparam logic [3:0] C_CMD_MUL = 4'd9;

    localparam logic [1:0] C_BR_NONE = 2'd0;
    localparam logic [1:0] C_BR_BEZ  = 2'd1;
    localparam logic [1:0] C_BR_BNE  = 2'd2;

    function automatic logic br_eval(input logic [1:0] t,
                                     input logic [DATA_W-1:0] a,
                                     input logic [DATA_W-1:0] b);
        case (t)
            C_BR_NONE: br_eval = 1'b0;
            C_BR_BEZ:  br_eval = (a == '0);
            C_BR_BNE:  br_eval = (a != b);
            default:   br_eval = 1'b1;
        endcase
    endfunction

    logic [0:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic [DATA_W-1:0] m_op1_q, m_op1_d;
    logic [DATA_W-1:0] m_op2_q, m_op2_d;
    logic [DATA_W-1:0] m_reg2_q, m_reg2_d;
    logic [DATA_W-1:0] m_pc_q, m_pc_d;
    logic [4:0]        m_dest_q, m_dest_d;
    logic [1:0]        m_br_q, m_br_d;
    logic              m_mr_q, m_mr_d;
    logic              m_mw_q, m_mw_d;
    logic              m_wb_q, m_wb_d;

    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] alu_result_q, alu_result_d;
    logic [DATA_W-1:0] st_val_q, st_val_d;
    logic [4:0]        dest_q, dest_d;
    logic              mem_r_en_q, mem_r_en_d;
    logic              mem_w_en_q, mem_w_en_d;
    logic              wb_en_q, wb_en_d;
    logic              br_taken_q, br_taken_d;
    logic [DATA_W-1:0] br_addr_q, br_addr_d;

    logic              w_freeze;
    logic              w_is_mul;
    logic              w_last;
    logic [DATA_W-1:0] w_alu_result;
    logic [DATA_W-1:0] w_acc_next;
    logic              w_ovf;

    assign w_is_mul   = (bus.exe_cmd == C_CMD_MUL);
    assign w_last     = (cnt_q == C_CNT_LAST);
    // Operands stay unshifted so a branch paired with MUL can still use them.
    assign w_acc_next = acc_q + (m_op2_q[cnt_q] ? (m_op1_q << cnt_q) : '0);

    always_comb begin
        w_alu_result = '0;
        case (bus.exe_cmd)
            C_CMD_ADD: w_alu_result = bus.val1 + bus.val2;
            C_CMD_SUB: w_alu_result = bus.val1 - bus.val2;
            C_CMD_AND: w_alu_result = bus.val1 & bus.val2;
            C_CMD_OR:  w_alu_result = bus.val1 | bus.val2;
            C_CMD_NOR: w_alu_result = ~(bus.val1 | bus.val2);
            C_CMD_XOR: w_alu_result = bus.val1 ^ bus.val2;
            C_CMD_SLL: w_alu_result = bus.val1 << bus.val2[4:0];
            C_CMD_SRA: w_alu_result = $signed(bus.val1) >>> bus.val2[4:0];
            C_CMD_SRL: w_alu_result = bus.val1 >> bus.val2[4:0];
            default:   w_alu_result = '0;
        endcase
    end

`ifdef EXE_OVF_TRAP_EN
    logic ovf_q, ovf_d;

    always_comb begin
        w_ovf = 1'b0;
        if (bus.exe_cmd == C_CMD_ADD)
            w_ovf = (bus.val1[MSB] == bus.val2[MSB]) && (w_alu_result[MSB] != bus.val1[MSB]);
        else if (bus.exe_cmd == C_CMD_SUB)
            w_ovf = (bus.val1[MSB] != bus.val2[MSB]) && (w_alu_result[MSB] != bus.val1[MSB]);
    end

    always_comb begin
        ovf_d = 1'b0;
        if (state_q == S_IDLE && bus.in_valid && !bus.flush && !w_is_mul)
            ovf_d = w_ovf;
    end

    always_ff @(posedge clk) begin
        if (rst) ovf_q <= 1'b0;
        else     ovf_q <= ovf_d;
    end

    assign bus.ovf = ovf_q;
`else
    assign w_ovf = 1'b0;
`endif

    // FSM: state register
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (bus.in_valid && !bus.flush && w_is_mul) state_d = S_BUSY;
            S_BUSY: if (bus.flush || w_last)                    state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM: outputs; freeze releases in the final iteration so upstream advances with the result.
    always_comb begin
        w_freeze = 1'b0;
        case (state_q)
            S_IDLE: w_freeze = bus.in_valid && !bus.flush && w_is_mul;
            S_BUSY: w_freeze = !bus.flush && !w_last;
            default: w_freeze = 1'b0;
        endcase
    end

    always_comb begin
        cnt_d        = cnt_q;
        acc_d        = acc_q;
        m_op1_d      = m_op1_q;
        m_op2_d      = m_op2_q;
        m_reg2_d     = m_reg2_q;
        m_pc_d       = m_pc_q;
        m_dest_d     = m_dest_q;
        m_br_d       = m_br_q;
        m_mr_d       = m_mr_q;
        m_mw_d       = m_mw_q;
        m_wb_d       = m_wb_q;
        out_valid_d  = 1'b0;
        alu_result_d = alu_result_q;
        st_val_d     = st_val_q;
        dest_d       = dest_q;
        mem_r_en_d   = 1'b0;
        mem_w_en_d   = 1'b0;
        wb_en_d      = 1'b0;
        br_taken_d   = 1'b0;
        br_addr_d    = br_addr_q;

        if (state_q == S_IDLE) begin
            if (bus.in_valid && !bus.flush) begin
                if (w_is_mul) begin
                    m_op1_d  = bus.val1;
                    m_op2_d  = bus.val2;
                    m_reg2_d = bus.reg2;
                    m_pc_d   = bus.pc_in;
                    m_dest_d = bus.dest_in;
                    m_br_d   = bus.br_type;
                    m_mr_d   = bus.mem_r_en_in;
                    m_mw_d   = bus.mem_w_en_in;
                    m_wb_d   = bus.wb_en_in;
                    acc_d    = '0;
                    cnt_d    = '0;
                end else begin
                    out_valid_d  = 1'b1;
                    alu_result_d = w_alu_result;
                    st_val_d     = bus.reg2;
                    dest_d       = bus.dest_in;
                    mem_r_en_d   = bus.mem_r_en_in;
                    mem_w_en_d   = bus.mem_w_en_in;
                    wb_en_d      = bus.wb_en_in & ~w_ovf;
                    br_taken_d   = br_eval(bus.br_type, bus.val1, bus.reg2);
                    if (bus.br_type != C_BR_NONE)
                        br_addr_d = bus.pc_in + (bus.val2 << 2);
                end
            end
        end else if (!bus.flush) begin
            acc_d = w_acc_next;
            cnt_d = cnt_q + CNT_W'(1);
            if (w_last) begin
                cnt_d        = '0;
                out_valid_d  = 1'b1;
                alu_result_d = w_acc_next;
                st_val_d     = m_reg2_q;
                dest_d       = m_dest_q;
                mem_r_en_d   = m_mr_q;
                mem_w_en_d   = m_mw_q;
                wb_en_d      = m_wb_q;
                br_taken_d   = br_eval(m_br_q, m_op1_q, m_reg2_q);
                if (m_br_q != C_BR_NONE)
                    br_addr_d = m_pc_q + (m_op2_q << 2);
            end
        end else begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q        <= '0;
            acc_q        <= '0;
            m_op1_q      <= '0;
            m_op2_q      <= '0;
            m_reg2_q     <= '0;
            m_pc_q       <= '0;
            m_dest_q     <= '0;
            m_br_q       <= '0;
            m_mr_q       <= 1'b0;
            m_mw_q       <= 1'b0;
            m_wb_q       <= 1'b0;
            out_valid_q  <= 1'b0;
            alu_result_q <= '0;
            st_val_q     <= '0;
            dest_q       <= '0;
            mem_r_en_q   <= 1'b0;
            mem_w_en_q   <= 1'b0;
            wb_en_q      <= 1'b0;
            br_taken_q   <= 1'b0;
            br_addr_q    <= '0;
        end else begin
            cnt_q        <= cnt_d;
            acc_q        <= acc_d;
            m_op1_q      <= m_op1_d;
            m_op2_q      <= m_op2_d;
            m_reg2_q     <= m_reg2_d;
            m_pc_q       <= m_pc_d;
            m_dest_q     <= m_dest_d;
            m_br_q       <= m_br_d;
            m_mr_q       <= m_mr_d;
            m_mw_q       <= m_mw_d;
            m_wb_q       <= m_wb_d;
            out_valid_q  <= out_valid_d;
            alu_result_q <= alu_result_d;
            st_val_q     <= st_val_d;
            dest_q       <= dest_d;
            mem_r_en_q   <= mem_r_en_d;
            mem_w_en_q   <= mem_w_en_d;
            wb_en_q      <= wb_en_d;
            br_taken_q   <= br_taken_d;
            br_addr_q    <= br_addr_d;
        end
    end

    assign bus.freeze     = w_freeze;
    assign bus.out_valid  = out_valid_q;
    assign bus.alu_result = alu_result_q;
    assign bus.st_val     = st_val_q;
    assign bus.dest       = dest_q;
    assign bus.mem_r_en   = mem_r_en_q;
    assign bus.mem_w_en   = mem_w_en_q;
    assign bus.wb_en      = wb_en_q;
    assign bus.br_taken   = br_taken_q;
    assign bus.br_addr    = br_addr_q;
endmodule
`default_nettype wire

// File: tb/tb_exe_stage_mc.sv
`default_nettype none
// ============================================================================
// Module   : tb_exe_stage_mc
// Purpose  : Self-checking bench for exe_stage_mc (vector table + scoreboard).
// Revision : 1.0 - initial release
// ============================================================================
module tb_exe_stage_mc;
    localparam bit OVF_EN =
`ifdef EXE_OVF_TRAP_EN
        1'b1;
`else
        1'b0;
`endif

    typedef struct {
        logic [3:0]  cmd;
        logic [1:0]  br;
        logic [31:0] v1, v2, r2, pc;
        logic [4:0]  dst;
        logic        mr, mw, wb;
        logic [31:0] e_res;
        logic        e_bt;
        logic [31:0] e_ba;
        logic        e_ovf;
    } vec_t;

    typedef struct {
        logic [31:0] res, st, ba;
        logic        chk_ba, bt, mr, mw, wb, ovf;
        logic [4:0]  dst;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    bit   chk_en = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   freeze_cnt = 0;
    exp_t sb[$];
    vec_t vecs[16];

    exe_stage_mc_if #(.DATA_W(32)) bus ();
    exe_stage_mc #(.DATA_W(32)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always begin
        @(negedge clk);
        #4;
        if (bus.freeze === 1'b1) freeze_cnt++;
    end

    // Scoreboard checker: every out_valid must match the oldest pending expectation.
    always begin
        @(posedge clk);
        #1;
        if (chk_en) begin
            if (bus.out_valid === 1'b1) begin
                if (sb.size() == 0) begin
                    chk("unexpected_out_valid", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("alu_result", bus.alu_result, e.res);
                    chk("st_val", bus.st_val, e.st);
                    chk("dest", {27'd0, bus.dest}, {27'd0, e.dst});
                    chk("wb_en", {31'd0, bus.wb_en}, {31'd0, e.wb});
                    chk("mem_r_en", {31'd0, bus.mem_r_en}, {31'd0, e.mr});
                    chk("mem_w_en", {31'd0, bus.mem_w_en}, {31'd0, e.mw});
                    chk("br_taken", {31'd0, bus.br_taken}, {31'd0, e.bt});
                    if (e.chk_ba) chk("br_addr", bus.br_addr, e.ba);
`ifdef EXE_OVF_TRAP_EN
                    chk("ovf", {31'd0, bus.ovf}, {31'd0, e.ovf});
`endif
                end
            end else begin
                chk("bubble_ctrl", {28'd0, bus.br_taken, bus.wb_en, bus.mem_r_en, bus.mem_w_en}, 32'd0);
            end
        end
    end

    task automatic idle();
        bus.in_valid = 1'b0;
        bus.flush    = 1'b0;
    endtask

    task automatic drive(input vec_t v, input bit push);
        exp_t e;
        bus.in_valid    = 1'b1;
        bus.exe_cmd     = v.cmd;
        bus.br_type     = v.br;
        bus.val1        = v.v1;
        bus.val2        = v.v2;
        bus.reg2        = v.r2;
        bus.pc_in       = v.pc;
        bus.dest_in     = v.dst;
        bus.mem_r_en_in = v.mr;
        bus.mem_w_en_in = v.mw;
        bus.wb_en_in    = v.wb;
        if (push) begin
            e.res    = v.e_res;
            e.st     = v.r2;
            e.ba     = v.e_ba;
            e.chk_ba = (v.br != 2'd0);
            e.bt     = v.e_bt;
            e.mr     = v.mr;
            e.mw     = v.mw;
            e.ovf    = v.e_ovf & OVF_EN;
            e.wb     = v.wb & ~(v.e_ovf & OVF_EN);
            e.dst    = v.dst;
            sb.push_back(e);
        end
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 60) begin
            @(posedge clk);
            #2;
            n++;
        end
        if (sb.size() != 0) begin
            chk("drain_timeout", sb.size(), 0);
            sb.delete();
        end
    endtask

    // Issue one instruction, drop in_valid after the first edge, count edges to the result.
    task automatic run_one(input vec_t v, input bit push, output int lat);
        @(negedge clk);
        drive(v, push);
        lat = 0;
        do begin
            @(posedge clk);
            #2;
            lat++;
            if (lat == 1) idle();
        end while (sb.size() != 0 && lat < 60);
        if (sb.size() != 0) begin
            chk("result_timeout", sb.size(), 0);
            sb.delete();
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_out_valid"}, {31'd0, bus.out_valid}, 32'd0);
        chk({tag, "_alu_result"}, bus.alu_result, 32'd0);
        chk({tag, "_st_val"}, bus.st_val, 32'd0);
        chk({tag, "_dest"}, {27'd0, bus.dest}, 32'd0);
        chk({tag, "_br_addr"}, bus.br_addr, 32'd0);
        chk({tag, "_freeze"}, {31'd0, bus.freeze}, 32'd0);
`ifdef EXE_OVF_TRAP_EN
        chk({tag, "_ovf"}, {31'd0, bus.ovf}, 32'd0);
`endif
    endtask

    function automatic vec_t mk(input logic [3:0] cmd, input logic [1:0] br,
                                input logic [31:0] v1, input logic [31:0] v2,
                                input logic [31:0] r2, input logic [31:0] pc,
                                input logic [4:0] dst, input logic [2:0] ctl,
                                input logic [31:0] res, input logic bt,
                                input logic [31:0] ba, input logic ovf);
        vec_t v;
        v.cmd = cmd; v.br = br; v.v1 = v1; v.v2 = v2; v.r2 = r2; v.pc = pc;
        v.dst = dst; v.mr = ctl[2]; v.mw = ctl[1]; v.wb = ctl[0];
        v.e_res = res; v.e_bt = bt; v.e_ba = ba; v.e_ovf = ovf;
        return v;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int lat;
        vec_t m;
        bus.flush = 1'b0; bus.in_valid = 1'b0; bus.exe_cmd = 4'd0; bus.br_type = 2'd0;
        bus.val1 = '0; bus.val2 = '0; bus.reg2 = '0; bus.pc_in = '0; bus.dest_in = '0;
        bus.mem_r_en_in = 1'b0; bus.mem_w_en_in = 1'b0; bus.wb_en_in = 1'b0;

        //            cmd  br  v1            v2            r2            pc          dst   ctl   result        bt  br_addr       ovf
        vecs[0]  = mk(4'd0, 0, 32'd5,        32'hFFFFFFFD, 32'h11,       32'h0,      5'd1, 3'b001, 32'd2,       0, 32'h0,        0);
        vecs[1]  = mk(4'd1, 0, 32'd3,        32'd5,        32'h22,       32'h0,      5'd2, 3'b101, 32'hFFFFFFFE, 0, 32'h0,       0);
        vecs[2]  = mk(4'd2, 0, 32'hF0F0FFFF, 32'h0FF000FF, 32'h0,        32'h0,      5'd3, 3'b010, 32'h00F000FF, 0, 32'h0,       0);
        vecs[3]  = mk(4'd3, 0, 32'hF0000000, 32'h0000000F, 32'h0,        32'h0,      5'd4, 3'b001, 32'hF000000F, 0, 32'h0,       0);
        vecs[4]  = mk(4'd4, 0, 32'h0F0F0F0F, 32'h00FF00FF, 32'h0,        32'h0,      5'd5, 3'b001, 32'hF000F000, 0, 32'h0,       0);
        vecs[5]  = mk(4'd5, 0, 32'hFF00FF00, 32'h0FF00FF0, 32'h0,        32'h0,      5'd6, 3'b001, 32'hF0F0F0F0, 0, 32'h0,       0);
        vecs[6]  = mk(4'd6, 0, 32'd1,        32'h1F,       32'h0,        32'h0,      5'd7, 3'b001, 32'h80000000, 0, 32'h0,       0);
        vecs[7]  = mk(4'd6, 0, 32'd3,        32'h21,       32'h0,        32'h0,      5'd8, 3'b001, 32'd6,        0, 32'h0,       0);
        vecs[8]  = mk(4'd7, 0, 32'h80000000, 32'd4,        32'h0,        32'h0,      5'd9, 3'b001, 32'hF8000000, 0, 32'h0,       0);
        vecs[9]  = mk(4'd8, 0, 32'h80000000, 32'd4,        32'h0,        32'h0,      5'd10, 3'b001, 32'h08000000, 0, 32'h0,      0);
        vecs[10] = mk(4'd12, 0, 32'h1234,    32'h5678,     32'h0,        32'h0,      5'd11, 3'b001, 32'd0,        0, 32'h0,       0);
        vecs[11] = mk(4'd0, 2, 32'd3,        32'd2,        32'd4,        32'h100,    5'd0, 3'b000, 32'd5,        1, 32'h108,     0);
        vecs[12] = mk(4'd0, 2, 32'd3,        32'd2,        32'd3,        32'h100,    5'd0, 3'b000, 32'd5,        0, 32'h108,     0);
        vecs[13] = mk(4'd0, 1, 32'd0,        32'hFFFFFFFF, 32'd0,        32'h200,    5'd0, 3'b000, 32'hFFFFFFFF, 1, 32'h1FC,     0);
        vecs[14] = mk(4'd0, 3, 32'd9,        32'd4,        32'd0,        32'h40,     5'd31, 3'b001, 32'd13,      1, 32'h50,      0);
        vecs[15] = mk(4'd1, 0, 32'h80000000, 32'd1,        32'h0,        32'h0,      5'd12, 3'b001, 32'h7FFFFFFF, 0, 32'h0,      1);

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_zero("reset");
        chk_en = 1'b1;

        // Single ADD: latency 1, no freeze
        freeze_cnt = 0;
        run_one(vecs[0], 1'b1, lat);
        chk("add_latency", lat, 1);
        chk("add_freeze_cnt", freeze_cnt, 0);

        // Back-to-back table stream
        freeze_cnt = 0;
        for (int i = 1; i < 16; i++) begin
            @(negedge clk);
            drive(vecs[i], 1'b1);
        end
        @(negedge clk);
        idle();
        drain();
        chk("table_freeze_cnt", freeze_cnt, 0);

        // ADD overflow case
        m = mk(4'd0, 0, 32'h7FFFFFFF, 32'd1, 32'h0, 32'h0, 5'd13, 3'b001, 32'h80000000, 0, 32'h0, 1);
        run_one(m, 1'b1, lat);

        // MUL: 32 freeze cycles, result on edge 33
        freeze_cnt = 0;
        m = mk(4'd9, 0, 32'd7, 32'hFFFFFFFD, 32'h55, 32'h0, 5'd14, 3'b001, 32'd7 * 32'hFFFFFFFD, 0, 32'h0, 0);
        run_one(m, 1'b1, lat);
        chk("mul_latency", lat, 33);
        chk("mul_freeze_cnt", freeze_cnt, 32);

        // MUL paired with BEZ: branch resolved at completion
        m = mk(4'd9, 1, 32'd0, 32'd6, 32'h0, 32'h300, 5'd15, 3'b000, 32'd0, 1, 32'h318, 0);
        run_one(m, 1'b1, lat);
        chk("mul_bez_latency", lat, 33);

        // Flush in IDLE: no result
        @(negedge clk);
        drive(vecs[0], 1'b0);
        bus.flush = 1'b1;
        @(posedge clk);
        #2;
        chk("flush_idle_valid", {31'd0, bus.out_valid}, 32'd0);
        idle();

        // Flush during BUSY at cnt=10
        m = mk(4'd9, 0, 32'd9, 32'd9, 32'h0, 32'h0, 5'd16, 3'b001, 32'd81, 0, 32'h0, 0);
        @(negedge clk);
        drive(m, 1'b0);
        @(posedge clk);
        #2;
        idle();
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("busy_freeze", {31'd0, bus.freeze}, 32'd1);
        bus.flush = 1'b1;
        #1;
        chk("flush_freeze_drop", {31'd0, bus.freeze}, 32'd0);
        @(posedge clk);
        #2;
        bus.flush = 1'b0;
        chk("flush_busy_valid", {31'd0, bus.out_valid}, 32'd0);
        m = mk(4'd0, 0, 32'd1, 32'd1, 32'h0, 32'h0, 5'd17, 3'b001, 32'd2, 0, 32'h0, 0);
        run_one(m, 1'b1, lat);
        chk("post_flush_add_latency", lat, 1);

        // Flush coinciding with MUL completion
        m = mk(4'd9, 0, 32'd5, 32'd5, 32'h0, 32'h0, 5'd18, 3'b001, 32'd25, 0, 32'h0, 0);
        @(negedge clk);
        drive(m, 1'b0);
        @(posedge clk);
        #2;
        idle();
        repeat (31) @(posedge clk);
        @(negedge clk);
        bus.flush = 1'b1;
        @(posedge clk);
        #2;
        bus.flush = 1'b0;
        chk("flush_last_valid", {31'd0, bus.out_valid}, 32'd0);
        repeat (3) @(posedge clk);

        // Reset during BUSY at cnt=20
        @(negedge clk);
        drive(m, 1'b0);
        @(posedge clk);
        #2;
        idle();
        repeat (20) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_zero("midmul_reset");
        @(negedge clk);
        rst = 1'b0;
        m = mk(4'd9, 0, 32'd3, 32'd4, 32'h0, 32'h0, 5'd19, 3'b001, 32'd12, 0, 32'h0, 0);
        run_one(m, 1'b1, lat);
        chk("post_reset_mul_latency", lat, 33);

        repeat (3) @(posedge clk);
        #3;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/exe_stage_mc.md
Name: exe_stage_mc

Overview:
- Consumer end of the ID/EX pipeline register in the multicycle MIPS core.
- Reads the decoded operands and control bits held in that register and executes ALU operations.
- Resolves branches and produces a registered EX/MEM payload.
- Single-cycle ops complete in 1 cycle. MUL runs on an iterative shift-add unit and holds the upstream register via freeze until done.

Parameters:
- DATA_W, 32, operand/result width; MUL iteration count equals DATA_W.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- flush  in  1  kill current/in-flight instruction.
- in_valid  in  1  ID/EX register holds a live instruction.
- val1  in  DATA_W  operand 1.
- val2  in  DATA_W  operand 2 / sign-extended immediate.
- reg2  in  DATA_W  rt value (store data, BNE compare).
- pc_in  in  DATA_W  PC+4 of instruction.
- dest_in  in  5  destination register.
- br_type  in  2  0 none, 1 BEZ, 2 BNE, 3 JMP.
- exe_cmd  in  4  0 ADD, 1 SUB, 2 AND, 3 OR, 4 NOR, 5 XOR, 6 SLL, 7 SRA, 8 SRL, 9 MUL; others give result 0.
- mem_r_en_in, mem_w_en_in, wb_en_in  in  1 each  control bits.
- freeze  out  1  hold ID/EX register and earlier stages.
- out_valid  out  1  EX/MEM payload valid.
- alu_result  out  DATA_W  result.
- st_val  out  DATA_W  registered reg2.
- dest  out  5  registered dest_in.
- mem_r_en, mem_w_en, wb_en  out  1 each  registered controls, zero when out_valid=0.
- br_taken  out  1  one-cycle pulse, branch taken.
- br_addr  out  DATA_W  branch target.

Behaviour:
- Reset: all outputs 0, state IDLE, counter 0. Reset has priority over everything, including mid-MUL; the partial product is discarded.
- States: IDLE, BUSY.

IDLE:
- Accept when in_valid=1 and flush=0.
- Non-MUL op: compute combinationally and register all outputs at the next edge; out_valid=1 (latency 1).
- MUL op: freeze=1 combinationally in that cycle. At the edge, capture multiplicand/multiplier, clear the accumulator, cnt=0, go to BUSY. out_valid=0 for that edge.
- in_valid=0: register a bubble (out_valid, control enables, br_taken all 0; data outputs hold).

BUSY:
- One shift-add iteration per cycle; low DATA_W bits kept, so signed and unsigned low results are identical.
- freeze=1 while cnt<DATA_W-1; freeze=0 in the cycle with cnt=DATA_W-1.
- At the edge ending cnt=DATA_W-1: write the product to alu_result, out_valid=1, register dest/controls, go to IDLE.
- Total freeze cycles = DATA_W. Result appears DATA_W+1 edges after the MUL was first presented.
- Inputs are ignored in BUSY; operands come only from the captured copies.

Arithmetic:
- ADD/SUB wrap modulo 2^DATA_W.
- Shifts use val1 shifted by val2[4:0]. SRA is arithmetic.
- freeze=0 whenever not required by MUL.

Branch (registered with the same latency as the result, only when accepted):
- BEZ: taken if val1==0.
- BNE: taken if val1!=reg2.
- JMP: always taken.
- br_addr = pc_in + (val2<<2), registered for any accepted branch.
- br_taken is a 1-cycle pulse.
- Branch with a MUL exe_cmd: the branch evaluates at the MUL completion edge.

flush:
- Synchronous, below rst.
- In IDLE: the next edge registers a bubble.
- In BUSY: abort to IDLE, out_valid=0, freeze drops the same cycle.
- flush and MUL completion in the same cycle: flush wins, no out_valid.

Optional Feature:
- Macro EXE_OVF_TRAP_EN.
- Defined: adds output ovf (1 bit, reset 0), registered with out_valid. It is set on signed overflow of ADD/SUB (operand signs per op disagree with the result sign). When set, wb_en is forced 0 for that instruction and mem_r_en/mem_w_en pass unchanged.
- Undefined: no ovf port; ADD/SUB wrap silently and wb_en passes through.

Test Plan:
- ADD val1=5, val2=0xFFFFFFFD, in_valid=1, wb_en_in=1 -> next edge: out_valid=1, alu_result=2, wb_en=1, freeze never high.
- MUL val1=7, val2=0xFFFFFFFD -> freeze high exactly 32 cycles, alu_result=0xFFFFFFEB with out_valid=1 on edge 33; no out_valid in between.
- BNE val1=3, reg2=4, pc_in=0x100, val2=2 -> br_taken pulse 1 cycle, br_addr=0x108. Repeat with reg2=3 -> br_taken=0.
- MUL started, flush asserted at BUSY cnt=10 -> freeze low the same cycle, out_valid stays 0, next ADD 1+1 gives alu_result=2 one cycle later.
- rst asserted at BUSY cnt=20 -> next edge all outputs 0, state IDLE, freeze=0. A MUL 3*4 afterwards gives 12 after 33 edges.
- EXE_OVF_TRAP_EN defined: ADD 0x7FFFFFFF+1, wb_en_in=1 -> ovf=1, wb_en=0, alu_result=0x80000000. Undefined: wb_en=1.
